// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - two-requester arbiter sharing one 3-bit ripple-carry adder

module parallel_adder_3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [3:0] q
);
  logic [3:0] c;

  assign c[0] = 1'b0;

  // Three chained full adders; the final carry becomes sum bit 3
  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign q[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign q[3] = c[3];
endmodule

module adder_share_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [2:0]       a0,
  input  logic [2:0]       b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [2:0]       a1,
  input  logic [2:0]       b1,
  output logic             gnt1,
  output logic [3:0]       sum,
  output logic             sum_id,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic [CNT_W-1:0] ops_count
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [2:0] op_a;
  logic [2:0] op_b;
  logic       win;
  logic       rr;
  logic       tie_to1;
  logic       pick1;
  logic [3:0] adder_q;

  // On a tie, round-robin follows the pointer; fixed priority always favours req0
  assign tie_to1 = (FIXED_PRIO == 0) ? rr : 1'b0;
  assign pick1   = req1 & (~req0 | tie_to1);
  assign busy    = (state != IDLE);

  parallel_adder_3bit u_adder (
    .a (op_a),
    .b (op_b),
    .q (adder_q)
  );

  // Arbitration FSM: capture winner's operands, register the sum, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= 3'd0;
      op_b      <= 3'd0;
      win       <= 1'b0;
      rr        <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      sum       <= 4'd0;
      sum_id    <= 1'b0;
      sum_valid <= 1'b0;
      ops_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          if (req0 | req1) begin
            win   <= pick1;
            op_a  <= pick1 ? a1 : a0;
            op_b  <= pick1 ? b1 : b0;
            gnt0  <= ~pick1;
            gnt1  <= pick1;
            state <= CALC;
          end
        end
        CALC: begin
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          sum       <= adder_q;
          sum_id    <= win;
          sum_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            ops_count <= ops_count + CNT_ONE;
            rr        <= ~win;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - scoreboard bench for adder_share_arbiter

module tb_adder_share_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, sum_ready;
  logic [2:0] a0, b0, a1, b1;

  logic       g0, g1, sid, sv, bz;
  logic [3:0] s;
  logic [7:0] oc;
  logic       fg0, fg1, fsid, fsv, fbz;
  logic [3:0] fs;
  logic [7:0] foc;
  logic       wg0, wg1, wsid, wsv, wbz;
  logic [3:0] ws;
  logic [1:0] woc;

  int tests_run = 0;
  int fails     = 0;
  bit rr_m      = 1'b0;
  int cnt_m     = 0;
  logic [4:0] q_main[$];
  logic [4:0] q_fp[$];

  always #5 clk = ~clk;

  adder_share_arbiter #(.FIXED_PRIO(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .a0(a0), .b0(b0), .gnt0(g0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(g1), .sum(s), .sum_id(sid),
    .sum_valid(sv), .sum_ready(sum_ready), .busy(bz), .ops_count(oc));

  adder_share_arbiter #(.FIXED_PRIO(1), .CNT_W(8)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req0(req0), .a0(a0), .b0(b0), .gnt0(fg0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(fg1), .sum(fs), .sum_id(fsid),
    .sum_valid(fsv), .sum_ready(sum_ready), .busy(fbz), .ops_count(foc));

  adder_share_arbiter #(.FIXED_PRIO(0), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .req0(req0), .a0(a0), .b0(b0), .gnt0(wg0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(wg1), .sum(ws), .sum_id(wsid),
    .sum_valid(wsv), .sum_ready(sum_ready), .busy(wbz), .ops_count(woc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rr_m  = 1'b0;
    cnt_m = 0;
    q_main.delete();
    q_fp.delete();
  endtask

  // Waits for any grant on the main DUT; returns cycles waited (99 on timeout)
  task automatic wait_gnt(output int cyc);
    cyc = 0;
    while (!(g0 | g1) && cyc < 12) begin
      tick();
      cyc++;
    end
    if (!(g0 | g1)) begin
      cyc = 99;
      tests_run++; fails++;
      $display("FAIL gnt_timeout: no grant within 12 cycles");
    end
  endtask

  // One operation from a single requester, consumer always ready
  task automatic single_op(input bit who, input logic [2:0] a, input logic [2:0] b);
    int cyc;
    logic [4:0] e;
    sum_ready = 1'b1;
    if (who) begin a1 = a; b1 = b; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; req0 = 1'b1; end
    q_main.push_back({who, {1'b0, a} + {1'b0, b}});
    wait_gnt(cyc);
    tests_run++;
    if (cyc !== 1) begin fails++; $display("FAIL gnt_latency: got %0d cycles exp 1", cyc); end
    tests_run++;
    if ({g1, g0} !== (who ? 2'b10 : 2'b01)) begin
      fails++; $display("FAIL gnt_owner: got %b exp %b", {g1, g0}, (who ? 2'b10 : 2'b01));
    end
    req0 = 1'b0; req1 = 1'b0;
    a0 = 3'd0; b0 = 3'd0; a1 = 3'd0; b1 = 3'd0;
    tick();
    tests_run++;
    if ({g1, g0} !== 2'b00) begin fails++; $display("FAIL gnt_pulse: got %b exp 00", {g1, g0}); end
    tests_run++;
    if (sv !== 1'b1) begin fails++; $display("FAIL sum_valid: got %b exp 1", sv); end
    e = q_main.pop_front();
    tests_run++;
    if ({sid, s} !== e) begin fails++; $display("FAIL result: got id%0d sum %0d exp id%0d sum %0d", sid, s, e[4], e[3:0]); end
    tick();
    rr_m = ~who;
    cnt_m++;
    tests_run++;
    if ({sv, bz} !== 2'b00) begin fails++; $display("FAIL accept_idle: got valid/busy %b exp 00", {sv, bz}); end
    tests_run++;
    if (oc !== cnt_m[7:0]) begin fails++; $display("FAIL ops_count: got %0d exp %0d", oc, cnt_m[7:0]); end
    tests_run++;
    if (woc !== cnt_m[1:0]) begin fails++; $display("FAIL ops_count_w2: got %0d exp %0d", woc, cnt_m[1:0]); end
  endtask

  // Both requesters held for n operations; checks round-robin and fixed-priority DUTs
  task automatic tie_ops(input int n);
    int cyc;
    bit w;
    logic [4:0] e;
    sum_ready = 1'b1;
    a0 = 3'd1; b0 = 3'd2; a1 = 3'd3; b1 = 3'd4;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = rr_m;
      q_main.push_back({w, w ? 4'd7 : 4'd3});
      q_fp.push_back({1'b0, 4'd3});
      wait_gnt(cyc);
      tests_run++;
      if ({g1, g0} !== (w ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL rr_gnt: op %0d got %b exp %b", i, {g1, g0}, (w ? 2'b10 : 2'b01));
      end
      tests_run++;
      if ({fg1, fg0} !== 2'b01) begin fails++; $display("FAIL fp_gnt: op %0d got %b exp 01", i, {fg1, fg0}); end
      tick();
      tests_run++;
      if ({g1, g0, fg1, fg0} !== 4'b0000) begin
        fails++; $display("FAIL tie_gnt_pulse: got %b exp 0000", {g1, g0, fg1, fg0});
      end
      e = q_main.pop_front();
      tests_run++;
      if ({sv, sid, s} !== {1'b1, e}) begin
        fails++; $display("FAIL rr_result: op %0d got v%0d id%0d sum %0d exp id%0d sum %0d", i, sv, sid, s, e[4], e[3:0]);
      end
      e = q_fp.pop_front();
      tests_run++;
      if ({fsv, fsid, fs} !== {1'b1, e}) begin
        fails++; $display("FAIL fp_result: op %0d got v%0d id%0d sum %0d exp id%0d sum %0d", i, fsv, fsid, fs, e[4], e[3:0]);
      end
      if (i == n - 1) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      rr_m = ~w;
      cnt_m++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; sum_ready = 1'b0;
    a0 = 3'd0; b0 = 3'd0; a1 = 3'd0; b1 = 3'd0;
    tick();
    tick();
    tests_run++;
    if ({g0, g1, s, sid, sv, bz} !== 9'd0) begin
      fails++; $display("FAIL reset_outputs: got %b exp 0", {g0, g1, s, sid, sv, bz});
    end
    tests_run++;
    if ({oc, foc, woc} !== 18'd0) begin fails++; $display("FAIL reset_count: got %0h exp 0", {oc, foc, woc}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    single_op(1'b0, 3'd6, 3'd7);
    single_op(1'b1, 3'd2, 3'd5);
  endtask

  task automatic test_tie_rr();
    reset_pulse();
    tie_ops(3);
  endtask

  task automatic test_fixed_prio();
    tie_ops(2);
    tests_run++;
    if (foc !== cnt_m[7:0]) begin fails++; $display("FAIL fp_ops_count: got %0d exp %0d", foc, cnt_m[7:0]); end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [4:0] e;
    sum_ready = 1'b0;
    a0 = 3'd5; b0 = 3'd4; req0 = 1'b1;
    q_main.push_back({1'b0, 4'd9});
    wait_gnt(cyc);
    req0 = 1'b0;
    a1 = 3'd2; b1 = 3'd3; req1 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({sv, s, g1, bz} !== {1'b1, 4'd9, 1'b0, 1'b1}) begin
        fails++; $display("FAIL bp_hold: cycle %0d got v%0d sum %0d gnt1 %0d busy %0d exp v1 sum 9 gnt1 0 busy 1", i, sv, s, g1, bz);
      end
      tick();
    end
    sum_ready = 1'b1;
    e = q_main.pop_front();
    tests_run++;
    if ({sid, s} !== e) begin fails++; $display("FAIL bp_result: got id%0d sum %0d exp id%0d sum %0d", sid, s, e[4], e[3:0]); end
    q_main.push_back({1'b1, 4'd5});
    tick();
    rr_m = 1'b1;
    cnt_m++;
    tests_run++;
    if ({sv, oc} !== {1'b0, cnt_m[7:0]}) begin fails++; $display("FAIL bp_accept: got v%0d cnt %0d exp v0 cnt %0d", sv, oc, cnt_m[7:0]); end
    tick();
    tests_run++;
    if (g1 !== 1'b1) begin fails++; $display("FAIL bp_gnt1: got %0d exp 1", g1); end
    req1 = 1'b0;
    tick();
    e = q_main.pop_front();
    tests_run++;
    if ({sv, sid, s} !== {1'b1, e}) begin fails++; $display("FAIL bp_result2: got v%0d id%0d sum %0d exp id%0d sum %0d", sv, sid, s, e[4], e[3:0]); end
    tick();
    rr_m = 1'b0;
    cnt_m++;
  endtask

  task automatic test_wrap();
    reset_pulse();
    single_op(1'b0, 3'd0, 3'd0);
    single_op(1'b0, 3'd7, 3'd7);
    single_op(1'b1, 3'd5, 3'd3);
    single_op(1'b0, 3'd2, 3'd6);
    single_op(1'b1, 3'd4, 3'd1);
  endtask

  task automatic test_reset_mid_hold();
    int cyc;
    sum_ready = 1'b0;
    a0 = 3'd3; b0 = 3'd3; req0 = 1'b1;
    wait_gnt(cyc);
    req0 = 1'b0;
    tick();
    tests_run++;
    if (sv !== 1'b1) begin fails++; $display("FAIL pre_reset_hold: got %0d exp 1", sv); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({g0, g1, s, sid, sv, bz} !== 9'd0) begin
      fails++; $display("FAIL async_reset_outputs: got %b exp 0", {g0, g1, s, sid, sv, bz});
    end
    tests_run++;
    if ({oc, woc} !== 10'd0) begin fails++; $display("FAIL async_reset_count: got %0h exp 0", {oc, woc}); end
    tick();
    rst_n = 1'b1;
    rr_m = 1'b0;
    cnt_m = 0;
    q_main.delete();
    q_fp.delete();
    single_op(1'b1, 3'd2, 3'd2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_rr();
    test_fixed_prio();
    test_backpressure();
    test_wrap();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
